// File: rtl/modmul_wb_arb.sv
// Writeback arbiter: multiplier results always win, adder results queue in a FIFO; write port is registered (1 cycle).
// Backpressure: ma_stall raises at DEPTH-1 entries; the multiplier stream is never stalled.
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 5
`endif

module modmul_wb_arb #(
    parameter int WIDTH = `WORDSZ,
    parameter int AW    = `RFSZLOG2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AW-1:0]            mm_rn,
    input  logic [WIDTH-1:0]         mm_res,
    input  logic [AW-1:0]            ma_rn,
    input  logic [WIDTH-1:0]         ma_res,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     ma_stall,
    output logic                     ovf_err,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0]    rn;
        logic [WIDTH-1:0] res;
    } ent_t;

    ent_t           mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    logic mm_v, ma_v, empty, full;
    logic pop, push, drop, do_push;
    ent_t head;

    assign mm_v  = (mm_rn != '0);
    assign ma_v  = (ma_rn != '0);
    assign empty = (fifo_cnt == '0);
    assign full  = (fifo_cnt == CW'(DEPTH));
    assign head  = mem[rd_ptr];

    // Adder results only enter the FIFO when they cannot go straight to the port.
    assign pop     = !mm_v && !empty;
    assign push    = ma_v && (mm_v || !empty);
    assign drop    = push && full && !pop;
    assign do_push = push && !drop;

    assign ma_stall = (fifo_cnt >= CW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{rn: ma_rn, res: ma_res};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            ovf_err  <= 1'b0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (mm_v) begin
                wr_en   <= 1'b1;
                wr_addr <= mm_rn;
                wr_data <= mm_res;
            end else if (pop) begin
                wr_en   <= 1'b1;
                wr_addr <= head.rn;
                wr_data <= head.res;
            end else if (ma_v) begin
                wr_en   <= 1'b1;
                wr_addr <= ma_rn;
                wr_data <= ma_res;
            end

            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (drop)    ovf_err <= 1'b1;

            case ({do_push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_modmul_wb_arb.sv
// Directed bench for modmul_wb_arb: priority, bypass, FIFO ordering, overflow and mid-run reset.
module tb_modmul_wb_arb;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    mm_rn;
    logic [WIDTH-1:0] mm_res;
    logic [AW-1:0]    ma_rn;
    logic [WIDTH-1:0] ma_res;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             ma_stall;
    logic             ovf_err;
    logic [$clog2(DEPTH):0] fifo_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    modmul_wb_arb #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mm_rn    (mm_rn),
        .mm_res   (mm_res),
        .ma_rn    (ma_rn),
        .ma_res   (ma_res),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ma_stall (ma_stall),
        .ovf_err  (ovf_err),
        .fifo_cnt (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int mrn, input int mres, input int arn, input int ares);
        mm_rn  = AW'(mrn);
        mm_res = WIDTH'(mres);
        ma_rn  = AW'(arn);
        ma_res = WIDTH'(ares);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        chk("rst_wr_en",   64'(wr_en),    0);
        chk("rst_wr_addr", 64'(wr_addr),  0);
        chk("rst_wr_data", 64'(wr_data),  0);
        chk("rst_cnt",     64'(fifo_cnt), 0);
        chk("rst_stall",   64'(ma_stall), 0);
        chk("rst_ovf",     64'(ovf_err),  0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single multiplier result, then idle holds address/data.
        drive(5, 'h1234, 0, 0);
        tick();
        chk("mm_en",   64'(wr_en),   1);
        chk("mm_addr", 64'(wr_addr), 5);
        chk("mm_data", 64'(wr_data), 'h1234);
        drive(0, 0, 0, 0);
        tick();
        chk("idle_en",   64'(wr_en),   0);
        chk("idle_hold", 64'(wr_addr), 5);

        // Adder bypass with empty FIFO.
        drive(0, 0, 3, 'hAA);
        tick();
        chk("byp_en",   64'(wr_en),    1);
        chk("byp_addr", 64'(wr_addr),  3);
        chk("byp_data", 64'(wr_data),  'hAA);
        chk("byp_cnt",  64'(fifo_cnt), 0);
        drive(0, 0, 0, 0);

        // Simultaneous results: multiplier first, adder one cycle later via FIFO.
        drive(7, 'h77, 9, 'h99);
        tick();
        chk("col_mm_addr", 64'(wr_addr),  7);
        chk("col_mm_data", 64'(wr_data),  'h77);
        chk("col_cnt1",    64'(fifo_cnt), 1);
        drive(0, 0, 0, 0);
        tick();
        chk("col_ma_en",   64'(wr_en),    1);
        chk("col_ma_addr", 64'(wr_addr),  9);
        chk("col_ma_data", 64'(wr_data),  'h99);
        chk("col_cnt0",    64'(fifo_cnt), 0);

        // Six-cycle multiplier burst while the adder delivers tags 1..4.
        for (int i = 0; i < 6; i++) begin
            drive(10 + i, 'h200 + 10 + i, (i < 4) ? i + 1 : 0, 'h100 + i + 1);
            tick();
            chk("burst_addr",  64'(wr_addr),  64'(10 + i));
            chk("burst_cnt",   64'(fifo_cnt), 64'((i < 4) ? i + 1 : 4));
            chk("burst_stall", 64'(ma_stall), 64'((i >= 2) ? 1 : 0));
        end
        chk("burst_ovf", 64'(ovf_err), 0);

        // Full FIFO, push without pop: adder result 21 is dropped.
        drive(20, 'h220, 21, 'h121);
        tick();
        chk("ovf_addr", 64'(wr_addr),  20);
        chk("ovf_set",  64'(ovf_err),  1);
        chk("ovf_cnt",  64'(fifo_cnt), 4);

        // Full FIFO, pop with simultaneous push of tag 26 is legal.
        drive(0, 0, 26, 'h126);
        tick();
        chk("fpp_addr", 64'(wr_addr),  1);
        chk("fpp_data", 64'(wr_data),  'h101);
        chk("fpp_cnt",  64'(fifo_cnt), 4);
        drive(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_en",   64'(wr_en),    1);
            chk("drain_addr", 64'(wr_addr),  64'((k < 3) ? k + 2 : 26));
            chk("drain_data", 64'(wr_data),  64'((k < 3) ? 'h100 + k + 2 : 'h126));
            chk("drain_cnt",  64'(fifo_cnt), 64'(3 - k));
            chk("drain_ovf",  64'(ovf_err),  1);
        end
        tick();
        chk("drained_en", 64'(wr_en), 0);

        // Buffer two entries then reset mid-operation.
        drive(22, 'h222, 23, 'h123);
        tick();
        drive(24, 'h224, 25, 'h125);
        tick();
        chk("pre_rst_cnt", 64'(fifo_cnt), 2);
        drive(0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en",   64'(wr_en),    0);
        chk("mid_rst_cnt",  64'(fifo_cnt), 0);
        chk("mid_rst_ovf",  64'(ovf_err),  0);
        chk("mid_rst_addr", 64'(wr_addr),  0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_en",  64'(wr_en),    0);
            chk("post_rst_cnt", 64'(fifo_cnt), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/modmul_wb_arb.md
Name: modmul_wb_arb

Overview:
- Writeback arbiter directly downstream of the modular multiplier and the modular adder.
- Merges their tagged result streams onto the single register-file write port.
- The multiplier stream cannot stall, so it always has priority. Adder results that lose arbitration wait in a small FIFO.
- Destination tag 0 is the null register: a result tagged 0 is "no result" and is never written.

Parameters:
- WIDTH, `WORDSZ, data width of results and the write port.
- AW, `RFSZLOG2, register-file address (tag) width.
- DEPTH, 4, adder-side FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mm_rn  in  AW  multiplier destination tag; 0 means no result this cycle.
- mm_res  in  WIDTH  multiplier result, valid when mm_rn != 0.
- ma_rn  in  AW  adder destination tag; 0 means no result this cycle.
- ma_res  in  WIDTH  adder result, valid when ma_rn != 0.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  WIDTH  write data.
- ma_stall  out  1  adder issue must hold; asserted when FIFO count >= DEPTH-1.
- ovf_err  out  1  sticky error: an adder result was dropped.
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy, for debug.

Behaviour:
- Reset (async, rst_n low):
  - wr_en, wr_addr, wr_data, ovf_err, fifo_cnt all go to 0; ma_stall goes to 0.
  - FIFO pointers clear; FIFO storage contents are don't-care.
  - Reset mid-operation discards all buffered entries with no write.
- Define mm_v = (mm_rn != 0) and ma_v = (ma_rn != 0).
- Each cycle exactly one winner is chosen; wr_* are registered, so the write appears the following cycle (latency 1).
- Priority order:
  1. mm_v: the multiplier wins and drives wr_* next cycle. If ma_v, the adder result is pushed to the FIFO.
  2. !mm_v and FIFO non-empty: the FIFO head is popped and written. If ma_v, the incoming adder result is pushed in the same cycle, so count is unchanged.
  3. !mm_v, FIFO empty, ma_v: bypass; the adder result is written next cycle with no FIFO write.
  4. None of the above: wr_en = 0 next cycle. wr_addr and wr_data hold their previous values.
- Ordering:
  - Adder results are written in arrival order.
  - Multiplier results are written in arrival order.
  - There is no ordering guarantee between the two streams.
- Same-tag collision (mm_rn == ma_rn != 0 in one cycle): the multiplier is written first and the adder later. The later write wins; this is intentional, and issue logic must avoid the collision if it matters.
- FIFO full:
  - Full means count == DEPTH.
  - If a push is required and no pop happens in that cycle, the adder result is dropped and ovf_err is set. ovf_err stays set until reset.
  - A push with a simultaneous pop when full is legal.
  - The FIFO cannot overflow if issue logic honours ma_stall, because ma_stall asserts at DEPTH-1, one entry of slack for the in-flight result.
- ma_stall is combinational from the registered count.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count is kept separately, so full and empty are unambiguous.
- Write-port throughput: at most 1 write per cycle. Sustained multiplier traffic starves the FIFO; this is accepted.

Test Plan:
- Reset, then mm_rn=5, mm_res=0x1234 for one cycle, ma_rn=0 -> next cycle wr_en=1, wr_addr=5, wr_data=0x1234; cycle after, wr_en=0.
- ma_rn=3, ma_res=0xAA with mm idle and FIFO empty -> bypass: wr_addr=3, wr_data=0xAA next cycle; fifo_cnt stays 0.
- mm_rn=7 and ma_rn=9 in the same cycle, then idle -> write 7 at cycle+1, write 9 at cycle+2; fifo_cnt reads 1 at cycle+1, then 0.
- mm_v held for 6 cycles while ma_v presents tags 1,2,3,4 on the first 4 cycles -> fifo_cnt reaches 4 and ma_stall=1 from count 3. After the mm burst ends, writes occur in order 1,2,3,4; ovf_err=0.
- FIFO full (count 4) with mm_v and ma_v both present -> adder result dropped, ovf_err=1 and it stays set; fifo_cnt stays 4.
- Pulse rst_n low while count=2 -> outputs and fifo_cnt go to 0 immediately; after release, the buffered entries are never written.
